// File: rtl/mem_requester.sv
// Memory requester: turns single datapath access requests into a
// MOV/MOC handshake with a bounded wait and an alignment check.
module mem_requester #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] MemDataOut
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          illegal;
    logic          sext;

    // Size/alignment check on the live request inputs.
    always_comb begin
        illegal = 1'b0;
        unique case (size)
            2'b00: illegal = 1'b0;
            2'b01: illegal = addr[0];
            2'b10: illegal = (addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Sign extension only makes sense for sub-word reads.
    assign sext = sign & rw & (size != 2'b10);

    // Request FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            MOV       <= 1'b0;
            MOCoff    <= 1'b1;
            ReadWrite <= 1'b0;
            MS_2_0    <= '0;
            Address   <= '0;
            DataIn    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    MOCoff <= 1'b0;
                    // The done cycle itself never accepts, leaving a gap.
                    if (req && !done) begin
                        if (illegal) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            MOV       <= 1'b1;
                            busy      <= 1'b1;
                            ReadWrite <= rw;
                            MS_2_0    <= {sext, size};
                            Address   <= addr;
                            DataIn    <= wdata;
                            cnt       <= '0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A late MOC on the timeout edge still wins.
                    if (MOC) begin
                        if (ReadWrite) rdata <= MemDataOut;
                        MOV    <= 1'b0;
                        MOCoff <= 1'b1;
                        state  <= RELEASE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        MOV       <= 1'b0;
                        MOCoff    <= 1'b1;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        ReadWrite <= 1'b0;
                        MS_2_0    <= '0;
                        Address   <= '0;
                        DataIn    <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!MOC) begin
                        MOCoff    <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ReadWrite <= 1'b0;
                        MS_2_0    <= '0;
                        Address   <= '0;
                        DataIn    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized bench for mem_requester with a transaction-level
// expectation model and a byte-addressed big-endian memory.
module tb_mem_requester;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        MOV;
    logic        ReadWrite;
    logic [2:0]  MS_2_0;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic        MOCoff;
    logic        MOC;
    logic [31:0] MemDataOut;

    mem_requester #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size),
        .sign(sign), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .err(err), .rdata(rdata), .MOV(MOV),
        .ReadWrite(ReadWrite), .MS_2_0(MS_2_0), .Address(Address),
        .DataIn(DataIn), .MOCoff(MOCoff), .MOC(MOC),
        .MemDataOut(MemDataOut)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [0:127];
    logic [31:0] exp_rdata;
    logic        c_rw;
    logic [1:0]  c_size;
    logic        c_sign;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the expected picture of this cycle.
    task automatic check_all(input string tag, input logic b,
                             input logic d, input logic e,
                             input logic mv, input logic mo,
                             input logic act);
        logic [2:0] ms;
        ms = 3'b000;
        if (act) begin
            ms[1:0] = c_size;
            ms[2] = c_sign && c_rw && (c_size != 2'b10);
        end
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".MOV"}, 32'(MOV), 32'(mv));
        chk({tag, ".MOCoff"}, 32'(MOCoff), 32'(mo));
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".ReadWrite"}, 32'(ReadWrite), act ? 32'(c_rw) : 32'd0);
        chk({tag, ".MS"}, 32'(MS_2_0), 32'(ms));
        chk({tag, ".Address"}, Address, act ? c_addr : 32'd0);
        chk({tag, ".DataIn"}, DataIn, act ? c_wdata : 32'd0);
    endtask

    function automatic bit is_legal(input logic [1:0] s,
                                    input logic [31:0] a);
        if (s == 2'b11) return 1'b0;
        if (s == 2'b01) return a[0] == 1'b0;
        if (s == 2'b10) return a[1:0] == 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] mem_read(input logic [1:0] s,
                                             input logic sg,
                                             input logic [31:0] a);
        int i;
        logic [31:0] v;
        i = int'(a[6:0]);
        if (s == 2'b00) begin
            v = {24'd0, mem[i]};
            if (sg && mem[i][7]) v[31:8] = 24'hFFFFFF;
        end else if (s == 2'b01) begin
            v = {16'd0, mem[i], mem[i+1]};
            if (sg && mem[i][7]) v[31:16] = 16'hFFFF;
        end else begin
            v = {mem[i], mem[i+1], mem[i+2], mem[i+3]};
        end
        return v;
    endfunction

    task automatic mem_write(input logic [1:0] s, input logic [31:0] a,
                             input logic [31:0] v);
        int i;
        i = int'(a[6:0]);
        if (s == 2'b00) begin
            mem[i] = v[7:0];
        end else if (s == 2'b01) begin
            mem[i] = v[15:8];
            mem[i+1] = v[7:0];
        end else begin
            mem[i] = v[31:24];
            mem[i+1] = v[23:16];
            mem[i+2] = v[15:8];
            mem[i+3] = v[7:0];
        end
    endtask

    task automatic drive_junk(input logic r);
        req   = r;
        rw    = 1'($urandom_range(1));
        size  = 2'($urandom_range(3));
        sign  = 1'($urandom_range(1));
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // d = idle WAIT edges before MOC; d >= TO means no answer at all.
    // r = extra edges MOC stays high after the acknowledge.
    task automatic run_txn(input logic t_rw, input logic [1:0] t_size,
                           input logic t_sign, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata,
                           input int d, input int r);
        int lim;
        logic [31:0] rd;
        c_rw = t_rw;
        c_size = t_size;
        c_sign = t_sign;
        c_addr = t_addr;
        c_wdata = t_wdata;
        req = 1'b1;
        rw = t_rw;
        size = t_size;
        sign = t_sign;
        addr = t_addr;
        wdata = t_wdata;
        MOC = 1'b0;
        step();
        if (!is_legal(t_size, t_addr)) begin
            check_all("illegal", 0, 1, 1, 0, 0, 0);
        end else begin
            check_all("accept", 1, 0, 0, 1, 0, 1);
            lim = (d < TO) ? d : TO;
            for (int k = 1; k <= lim; k++) begin
                drive_junk(1'($urandom_range(1)));
                MOC = 1'b0;
                MemDataOut = $urandom;
                step();
                if (k < TO) check_all("wait", 1, 0, 0, 1, 0, 1);
                else check_all("timeout", 0, 1, 1, 0, 1, 0);
            end
            if (d < TO) begin
                drive_junk(1'($urandom_range(1)));
                MOC = 1'b1;
                if (t_rw) begin
                    rd = mem_read(t_size, t_sign, t_addr);
                    MemDataOut = rd;
                    exp_rdata = rd;
                end else begin
                    MemDataOut = $urandom;
                    mem_write(t_size, t_addr, t_wdata);
                end
                step();
                check_all("ack", 1, 0, 0, 0, 1, 1);
                for (int k = 0; k < r; k++) begin
                    drive_junk(1'($urandom_range(1)));
                    step();
                    check_all("hold", 1, 0, 0, 0, 1, 1);
                end
                drive_junk(1'($urandom_range(1)));
                MOC = 1'b0;
                step();
                check_all("done", 0, 1, 0, 0, 0, 0);
            end
        end
        drive_junk(1'b1);
        MOC = 1'b0;
        step();
        check_all("gap", 0, 0, 0, 0, 0, 0);
        req = 1'b0;
    endtask

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int          d;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        exp_rdata = 32'd0;
        c_rw = 0; c_size = 0; c_sign = 0; c_addr = 0; c_wdata = 0;
        reset = 1'b1;
        drive_junk(1'b1);
        MOC = 1'b0;
        MemDataOut = 32'd0;
        @(negedge clk);
        step();
        check_all("reset", 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        req = 1'b0;
        step();
        check_all("reset_rel", 0, 0, 0, 0, 0, 0);

        // Word write, MOV high two cycles.
        run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 0);
        chk("lit_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
        // Signed byte read, minimum latency.
        run_txn(1'b1, 2'b00, 1'b1, 32'h13, 32'h0, 0, 0);
        chk("lit_sbyte", rdata, 32'hFFFFFFEF);
        // Misaligned halfword.
        run_txn(1'b1, 2'b01, 1'b0, 32'h11, 32'h0, 0, 0);
        // No answer: timeout.
        run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, TO, 0);
        // MOC on the very edge the counter would expire.
        run_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0, TO - 1, 2);
        chk("lit_half", rdata, 32'h0000BEEF);

        // Reset in the middle of WAIT.
        c_rw = 1'b1; c_size = 2'b10; c_sign = 1'b0;
        c_addr = 32'h20; c_wdata = 32'h0;
        req = 1'b1; rw = 1'b1; size = 2'b10; sign = 1'b0;
        addr = 32'h20; wdata = 32'h0;
        step();
        check_all("r_accept", 1, 0, 0, 1, 0, 1);
        req = 1'b0;
        step();
        step();
        check_all("r_wait", 1, 0, 0, 1, 0, 1);
        reset = 1'b1;
        exp_rdata = 32'd0;
        step();
        check_all("r_abort", 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        step();
        check_all("r_rel", 0, 0, 0, 0, 0, 0);
        run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1);
        chk("lit_word", rdata, 32'hDEADBEEF);

        for (int n = 0; n < 80; n++) begin
            s = 2'($urandom_range(3));
            a = 32'($urandom_range(60));
            if ($urandom_range(3) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                if (s == 2'b10) a[1:0] = 2'b00;
            end
            d = ($urandom_range(7) == 0) ? int'($urandom_range(TO + 2, TO - 2))
                                         : int'($urandom_range(4));
            run_txn(1'($urandom_range(1)), s, 1'($urandom_range(1)), a,
                    $urandom, d, int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
